system_join_responder: RTL

Parent-side responder for the tree-formation handshake of the system-message layer. Accepts S_PARENT_REQUEST and S_JOIN_REQUEST messages addressed to this node, answers with S_PARENT_ACK and S_JOIN_ACK, and allocates child IDs. It keeps a committed child counter and allows one offer in flight at a time. It sits between the system-message receive path and the system-message transmit arbiter of a node that has already joined the network.

---
 rtl/system_join_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/system_join_responder.sv
// Parent-side responder for tree formation: answers PARENT_REQUEST with PARENT_ACK,
// waits for the matching JOIN_REQUEST, commits a child and answers with JOIN_ACK.
module system_join_responder #(
  parameter int MAX_CHILDREN = 8,
  parameter int TIMEOUT      = 256,
  localparam int CW          = $clog2(MAX_CHILDREN) + 1,
  localparam int TW          = $clog2(TIMEOUT) + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          enable,
  input  logic [7:0]    this_id,
  input  logic [7:0]    global_id,
  input  logic [7:0]    child_id_base,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [7:0]    rx_header,
  input  logic [63:0]   rx_payload,
  input  logic [7:0]    rx_src_id,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_header,
  output logic [63:0]   tx_payload,
  output logic [7:0]    tx_dst_id,
  output logic [CW-1:0] child_count,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  // Handshake: rx and tx both transfer on a cycle where valid && ready is high.
  // rx_ready is a function of state only; tx fields hold while tx_valid && !tx_ready.

  localparam logic [7:0] S_NOPE           = 8'd0;
  localparam logic [7:0] S_RESET          = 8'd2;
  localparam logic [7:0] S_PARENT_REQUEST = 8'd3;
  localparam logic [7:0] S_PARENT_ACK     = 8'd4;
  localparam logic [7:0] S_JOIN_REQUEST   = 8'd5;
  localparam logic [7:0] S_JOIN_ACK       = 8'd6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_PACK = 2'd1,
    WAIT_JOIN = 2'd2,
    SEND_JACK = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      requester_q, requester_d;
  logic [7:0]      offer_q, offer_d;
  logic            is_init_q, is_init_d;
  logic [7:0]      parent_q, parent_d;
  logic [7:0]      gid_q, gid_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   count_q, count_d;

  logic rx_fire;
  logic is_preq;
  logic is_jreq;
  logic is_rst;
  logic join_match;
  logic count_full;
  logic timer_done;

  assign rx_ready   = (state_q == IDLE) || (state_q == WAIT_JOIN);
  assign rx_fire    = rx_valid && rx_ready;
  assign is_preq    = rx_fire && (rx_header == S_PARENT_REQUEST);
  assign is_jreq    = rx_fire && (rx_header == S_JOIN_REQUEST);
  assign is_rst     = rx_fire && (rx_header == S_RESET);
  assign join_match = is_jreq && (rx_src_id == requester_q) &&
                      (rx_payload[62:55] == this_id) &&
                      (rx_payload[54:47] == offer_q);
  assign count_full = (count_q >= CW'(MAX_CHILDREN));
  assign timer_done = (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      requester_q <= 8'd0;
      offer_q     <= 8'd0;
      is_init_q   <= 1'b0;
      parent_q    <= 8'd0;
      gid_q       <= 8'd0;
      timer_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      requester_q <= requester_d;
      offer_q     <= offer_d;
      is_init_q   <= is_init_d;
      parent_q    <= parent_d;
      gid_q       <= gid_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    requester_d = requester_q;
    offer_d     = offer_q;
    is_init_d   = is_init_q;
    parent_d    = parent_q;
    gid_d       = gid_q;
    timer_d     = timer_q;
    count_d     = count_q;
    tx_valid    = 1'b0;
    tx_header   = S_NOPE;
    tx_payload  = 64'd0;
    tx_dst_id   = 8'd0;

    case (state_q)
      IDLE: begin
        if (is_rst) begin
          count_d = '0;
        end else if (is_preq && enable && !count_full) begin
          requester_d = rx_src_id;
          offer_d     = child_id_base + 8'(count_q);
          is_init_d   = rx_payload[63];
          // Own/global IDs are captured so the ack fields cannot move under back-pressure.
          parent_d    = this_id;
          gid_d       = global_id;
          state_d     = SEND_PACK;
        end
      end
      SEND_PACK: begin
        tx_valid   = 1'b1;
        tx_header  = S_PARENT_ACK;
        tx_dst_id  = requester_q;
        tx_payload = {is_init_q, parent_q, offer_q, gid_q, 39'd0};
        if (tx_ready) begin
          timer_d = '0;
          state_d = WAIT_JOIN;
        end
      end
      WAIT_JOIN: begin
        timer_d = timer_q + 1'b1;
        if (is_rst) begin
          count_d = '0;
          state_d = IDLE;
        end else if (join_match) begin
          // A match arriving on the timeout cycle still commits.
          count_d = count_q + 1'b1;
          state_d = SEND_JACK;
        end else if (timer_done) begin
          state_d = IDLE;
        end
      end
      SEND_JACK: begin
        tx_valid   = 1'b1;
        tx_header  = S_JOIN_ACK;
        tx_dst_id  = requester_q;
        tx_payload = {is_init_q, 8'(count_q), parent_q, offer_q, 39'd0};
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign child_count = count_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

  a_tx_hold: assert property (@(posedge clk) disable iff (!nrst)
    (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_header) &&
                                 $stable(tx_payload) && $stable(tx_dst_id)));

  a_count_bound: assert property (@(posedge clk) disable iff (!nrst)
    count_q <= CW'(MAX_CHILDREN));

endmodule
